// File: rtl/speaker_tone.sv
// Parking-sensor sounder: square-wave tone at a note-dependent pitch, gated into
// beeps whose silent gap scales with the latched obstacle distance.
module speaker_tone #(
    parameter int HALF_MAX    = 113636,
    parameter int HALF_STEP   = 4000,
    parameter int BEEP_ON_CYC = 5000000,
    parameter int GAP_PER_CM  = 100000,
    parameter int CONT_CM     = 10,
    parameter int MUTE_CM     = 400
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] distance_cm,
    input  logic [4:0] speaker_note,
    output logic       speaker_out,
    output logic       beep_active
);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    localparam logic [16:0] HALF_MAX_W   = 17'(HALF_MAX);
    localparam logic [16:0] HALF_STEP_W  = 17'(HALF_STEP);
    localparam logic [22:0] BURST_LAST   = 23'(BEEP_ON_CYC - 1);
    localparam logic [26:0] GAP_PER_CM_W = 27'(GAP_PER_CM);
    localparam logic [8:0]  CONT_W       = 9'(CONT_CM);
    localparam logic [9:0]  MUTE_W       = 10'(MUTE_CM);

    state_t      state, state_n;
    logic [16:0] tone_cnt, tone_cnt_n;
    logic [22:0] burst_cnt, burst_cnt_n;
    logic [26:0] gap_cnt, gap_cnt_n;
    logic [4:0]  note_l, note_l_n;
    logic [8:0]  dist_l, dist_l_n;
    logic        spk_n, beep_n;

    logic        in_valid;
    logic [4:0]  note_clamp;
    logic [16:0] half_l;
    logic        tone_wrap;
    logic        burst_end;
    logic [26:0] gap_load;

    // distance 0 means "no echo yet", so it is silent just like out-of-range
    assign in_valid   = enable && (distance_cm != 9'd0) && ({1'b0, distance_cm} < MUTE_W);
    assign note_clamp = (speaker_note > 5'd16) ? 5'd16 : speaker_note;
    assign half_l     = HALF_MAX_W - HALF_STEP_W * {12'd0, note_l};

    // >= rather than == so a continuous-mode re-latch to a shorter half-period
    // cannot leave tone_cnt stranded above the new terminal count
    assign tone_wrap  = (tone_cnt >= (half_l - 17'd1));
    assign burst_end  = (burst_cnt == BURST_LAST);

    // counted down to 0 inclusive, hence the -1 to get exactly dist*GAP cycles
    assign gap_load   = GAP_PER_CM_W * {18'd0, dist_l} - 27'd1;

    always_comb begin
        state_n     = state;
        tone_cnt_n  = tone_cnt;
        burst_cnt_n = burst_cnt;
        gap_cnt_n   = gap_cnt;
        note_l_n    = note_l;
        dist_l_n    = dist_l;
        spk_n       = speaker_out;
        beep_n      = beep_active;

        case (state)
            IDLE: begin
                spk_n       = 1'b0;
                beep_n      = 1'b0;
                tone_cnt_n  = '0;
                burst_cnt_n = '0;
                gap_cnt_n   = '0;
                if (in_valid) begin
                    note_l_n = note_clamp;
                    dist_l_n = distance_cm;
                    state_n  = TONE;
                    spk_n    = 1'b1;
                    beep_n   = 1'b1;
                end
            end

            TONE: begin
                if (!enable) begin
                    state_n     = IDLE;
                    spk_n       = 1'b0;
                    beep_n      = 1'b0;
                    tone_cnt_n  = '0;
                    burst_cnt_n = '0;
                    gap_cnt_n   = '0;
                end else begin
                    if (tone_wrap) begin
                        tone_cnt_n = '0;
                        spk_n      = ~speaker_out;
                    end else begin
                        tone_cnt_n = tone_cnt + 17'd1;
                    end

                    if (!burst_end) begin
                        burst_cnt_n = burst_cnt + 23'd1;
                    end else if (!in_valid) begin
                        state_n     = IDLE;
                        spk_n       = 1'b0;
                        beep_n      = 1'b0;
                        tone_cnt_n  = '0;
                        burst_cnt_n = '0;
                        gap_cnt_n   = '0;
                    end else if (dist_l < CONT_W) begin
                        // continuous: new burst, tone phase runs on untouched
                        note_l_n    = note_clamp;
                        dist_l_n    = distance_cm;
                        burst_cnt_n = '0;
                    end else begin
                        state_n     = GAP;
                        spk_n       = 1'b0;
                        beep_n      = 1'b0;
                        tone_cnt_n  = '0;
                        burst_cnt_n = '0;
                        gap_cnt_n   = gap_load;
                    end
                end
            end

            GAP: begin
                if (!enable) begin
                    state_n     = IDLE;
                    spk_n       = 1'b0;
                    beep_n      = 1'b0;
                    tone_cnt_n  = '0;
                    burst_cnt_n = '0;
                    gap_cnt_n   = '0;
                end else if (gap_cnt != 27'd0) begin
                    gap_cnt_n = gap_cnt - 27'd1;
                end else if (in_valid) begin
                    note_l_n    = note_clamp;
                    dist_l_n    = distance_cm;
                    state_n     = TONE;
                    spk_n       = 1'b1;
                    beep_n      = 1'b1;
                    tone_cnt_n  = '0;
                    burst_cnt_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n     = IDLE;
                spk_n       = 1'b0;
                beep_n      = 1'b0;
                tone_cnt_n  = '0;
                burst_cnt_n = '0;
                gap_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tone_cnt    <= '0;
            burst_cnt   <= '0;
            gap_cnt     <= '0;
            note_l      <= '0;
            dist_l      <= '0;
            speaker_out <= 1'b0;
            beep_active <= 1'b0;
        end else begin
            state       <= state_n;
            tone_cnt    <= tone_cnt_n;
            burst_cnt   <= burst_cnt_n;
            gap_cnt     <= gap_cnt_n;
            note_l      <= note_l_n;
            dist_l      <= dist_l_n;
            speaker_out <= spk_n;
            beep_active <= beep_n;
        end
    end

endmodule

// File: doc/speaker_tone.md
# speaker_tone

Downstream consumer of the distance meter stage: takes the registered `distance_cm` and `speaker_note` values and drives the speaker pin with a parking-sensor style signal.
- The output is a square-wave tone whose pitch follows `speaker_note`.
- The tone is gated into beeps whose silent gap shrinks as the obstacle gets closer.
- Fully synchronous to the 100 MHz system clock.
- Inputs are sampled only at beep boundaries, so pitch and cadence never glitch mid-beep.

## Interface
Parameters:
- HALF_MAX, 113636: half-period in cycles for note 0 (~440 Hz).
- HALF_STEP, 4000: half-period decrement per note step.
- BEEP_ON_CYC, 5000000: beep length in cycles (50 ms).
- GAP_PER_CM, 100000: silent-gap cycles per cm of latched distance (1 ms/cm).
- CONT_CM, 10: latched distance below this gives a continuous tone.
- MUTE_CM, 400: distance at or above this is silent.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  sounder enable, level.
- distance_cm  in  9  distance from the meter stage, cm.
- speaker_note  in  5  note index from the meter stage.
- speaker_out  out  1  square-wave drive to the speaker, registered.
- beep_active  out  1  high while in TONE, registered.

## Operation
- Valid input: enable==1 and 0 < distance_cm < MUTE_CM. distance_cm==0 means no measurement and is treated as silent.
- Latch event: store note_l = min(speaker_note,16) and dist_l = distance_cm. Then compute half_l = HALF_MAX − note_l·HALF_STEP as a 17-bit value.
- States:
  - IDLE: speaker_out=0, beep_active=0. On valid input, latch and go to TONE.
  - TONE: beep_active=1. tone_cnt counts to half_l−1, then speaker_out toggles and tone_cnt clears. burst_cnt counts to BEEP_ON_CYC−1. At burst end:
    - invalid input → IDLE.
    - else dist_l < CONT_CM → re-latch and stay in TONE. Square-wave phase and tone_cnt continue, so there is no gap.
    - else → GAP with gap_cnt = dist_l·GAP_PER_CM (27-bit product).
  - GAP: speaker_out=0, beep_active=0. gap_cnt counts down. At 0: valid input → re-latch and go to TONE; otherwise → IDLE.
- enable low in TONE or GAP forces IDLE on the next edge, abandoning the beep or gap.
- Changes to distance_cm or speaker_note during a beep or gap have no effect until the next latch event.
- Counters: tone_cnt 17 b, burst_cnt 23 b, gap_cnt 27 b. They never wrap, because they are reloaded at every state entry.

## Timing
- Reset (async, reset==0): state=IDLE, all counters 0, speaker_out=0, beep_active=0. Takes effect immediately, including mid-beep.
- Synchronous release: the first transition is possible on the first rising edge with reset==1.
- IDLE→TONE: on the edge that sees valid input, speaker_out=1 and beep_active=1 both become visible after that edge.
- speaker_out stays at each level for exactly half_l cycles.
- Beep length is exactly BEEP_ON_CYC cycles of beep_active=1.
- Gap length is exactly dist_l·GAP_PER_CM cycles of beep_active=0.
- GAP→TONE: speaker_out=1 on the first TONE cycle, so each beep starts high.
- Continuous mode: no dead cycle between bursts. beep_active stays 1.
- Simultaneous events:
  - enable falling on a burst-end or gap-end cycle → IDLE. Disable wins.
  - A latch event and an input change on the same edge → the new input value is latched.

## Test plan
All scenarios use HALF_MAX=20, HALF_STEP=1, BEEP_ON_CYC=100, GAP_PER_CM=2, CONT_CM=10, MUTE_CM=400.
- Reset: reset=0 with enable=1, dist=100 → speaker_out=0, beep_active=0 throughout. Releasing reset starts a beep on the first edge.
- Normal beeping: note=3, dist=100, enable=1 → speaker_out alternates high/low every 17 cycles for 100 cycles, then is low for 200 cycles, then the pattern repeats starting high.
- Continuous mode and clamp: dist=5, note=20 → note clamped to 16, square wave with half-period 4, beep_active never drops over 500 cycles.
- Mute: dist=0 and then dist=450 with enable=1 → state stays IDLE, speaker_out=0 for 1000 cycles.
- Latch discipline: note changes 3→10 at cycle 30 of a beep → half-period stays 17 until the beep ends. The next beep uses half-period 10, and its gap length comes from dist latched at that beep's start.
- Abort: enable dropped mid-GAP → IDLE next edge. reset asserted mid-TONE with speaker_out=1 → speaker_out=0 immediately, with no clock edge required.
